// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } arb_state_t;

  localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set request scanning ptr, ptr+1, ... modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       sum;

  assign any = |req;

  always_comb begin
    // rot[k] holds req[(ptr + k) mod NREQ]; lowest set k wins
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    idx = '0;
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
        idx = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx between NREQ byte streams.
// state     | meaning
// IDLE      | no lock; arbitrate among valid requesters
// SEND      | lock held; wait for owner byte and idle transmitter
// START     | start pulse on tx_start
// WAIT_BUSY | wait for transmitter to drop ready
// WAIT_DONE | wait for frame end; release on last byte
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IW      = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [IW-1:0]     grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [TW:0] TO_LIM = (TW+1)'(TIMEOUT);

  arb_state_t  state, state_nx;
  logic [IW-1:0] rr_ptr, rr_nx, grant_nx, grant_inc, pick_idx;
  logic        busy_nx, last_r, last_nx, start_nx, to_nx, pick_any;
  logic        own_valid, own_last, to_hit;
  logic [7:0]  data_nx, own_data;
  logic [TW-1:0] cnt, cnt_nx;
  logic [7:0]  data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[8*i +: 8];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_valid = req_valid[grant];
  assign own_last  = req_last[grant];
  assign own_data  = data_arr[grant];
  assign grant_inc = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
  assign to_hit    = (TIMEOUT != 0) && (({1'b0, cnt} + 1'b1) == TO_LIM);

  always_comb begin
    req_ready = '0;
    if (state == SEND && tx_ready && own_valid) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    busy_nx  = busy;
    rr_nx    = rr_ptr;
    last_nx  = last_r;
    data_nx  = tx_data;
    cnt_nx   = cnt;
    start_nx = 1'b0;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nx = pick_idx;
          busy_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (own_valid && tx_ready) begin
          data_nx  = own_data;
          last_nx  = own_last;
          start_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = START;
        end else if (!own_valid) begin
          if (cnt != '1) cnt_nx = cnt + 1'b1;
          if (to_hit) begin
            to_nx    = 1'b1;
            busy_nx  = 1'b0;
            rr_nx    = grant_inc;
            state_nx = IDLE;
          end
        end
      end
      START: state_nx = WAIT_BUSY;
      // ready may still read 1 from before the start; wait for it to fall first
      WAIT_BUSY: if (!tx_ready) state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_ready) begin
          if (last_r) begin
            busy_nx  = 1'b0;
            rr_nx    = grant_inc;
            state_nx = IDLE;
          end else begin
            state_nx = SEND;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      last_r      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_nx;
      grant       <= grant_nx;
      busy        <= busy_nx;
      last_r      <= last_nx;
      tx_start    <= start_nx;
      tx_data     <= data_nx;
      cnt         <= cnt_nx;
      timeout_err <= to_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: message-level round-robin reference model plus a uart_tx ready model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4, IW = 2, TIMEOUT = 8, TW = 10, FRAME = 20;

  logic clk = 1'b0, rstn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [8*NREQ-1:0] req_data = '0;
  logic              tx_start, tx_ready, busy, timeout_err;
  logic [7:0]        tx_data;
  logic [IW-1:0]     grant;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .IW(IW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  // transmitter: ready low for FRAME cycles starting the cycle after a start pulse
  int   busy_cnt = 0;
  logic hold_low = 1'b0;
  always @(posedge clk) begin
    if (!rstn)          busy_cnt <= 0;
    else if (tx_start)  busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_ready = (busy_cnt == 0) && !hold_low;

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { int own; logic [7:0] data; } xfer_t;

  logic [8:0] drv_q [NREQ][$];   // {last, data} presented by each requester
  logic [8:0] mdl_q [NREQ][$];   // same messages, consumed by the reference model
  int         gap [NREQ];
  int         gmax = 0;
  xfer_t      exp_acc[$];        // predicted accept order
  logic [7:0] exp_tx[$];         // accepted bytes awaiting their start pulse
  int         rr_m = 0;
  logic [NREQ-1:0] fire_q = '0;
  logic       start_exp = 1'b0;
  int         nstart = 0, nto = 0, cyc = 0, to_cyc = -1, fire_cyc = -1;
  int         grant_log[$];

  task automatic load_byte(input int r, input logic [7:0] d, input logic last);
    drv_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic load_msg(input int r, input int len);
    for (int k = 0; k < len; k++)
      load_byte(r, 8'($urandom_range(0, 255)), (k == len - 1));
  endtask

  // round-robin at message granularity: owner keeps the transmitter until its last byte
  task automatic plan();
    bit found;
    int r;
    logic [8:0] e;
    xfer_t x;
    forever begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        r = (rr_m + k) % NREQ;
        if (!found && mdl_q[r].size() > 0) begin
          found = 1;
          do begin
            e = mdl_q[r].pop_front();
            x.own = r;
            x.data = e[7:0];
            exp_acc.push_back(x);
          end while (!e[8] && mdl_q[r].size() > 0);
          rr_m = (r + 1) % NREQ;
        end
      end
      if (!found) break;
    end
  endtask

  task automatic apply_drivers();
    for (int i = 0; i < NREQ; i++) begin
      if (gap[i] > 0) begin
        gap[i]--;
        req_valid[i] = 1'b0;
      end else if (drv_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = drv_q[i][0][7:0];
        req_last[i] = drv_q[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    xfer_t x;
    @(negedge clk);
    cyc++;
    check("tx_start", tx_start, start_exp);
    if (tx_start) begin
      nstart++;
      grant_log.push_back(int'(grant));
      if (exp_tx.size() > 0) check("tx_data", tx_data, exp_tx.pop_front());
      else check("tx_start_extra", 1, 0);
    end
    fire_q = req_valid & req_ready;
    if (req_ready != '0) begin
      fire_cyc = cyc;
      if (exp_acc.size() > 0) begin
        x = exp_acc.pop_front();
        check("req_ready", req_ready, 64'(1) << x.own);
        check("grant", grant, x.own);
        check("busy_on_accept", busy, 1);
        exp_tx.push_back(x.data);
      end else begin
        check("req_ready_unexpected", req_ready, 0);
      end
    end
    start_exp = (fire_q != '0);
    if (timeout_err) begin
      nto++;
      to_cyc = cyc;
      check("busy_at_timeout", busy, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (fire_q[i]) begin
        void'(drv_q[i].pop_front());
        gap[i] = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      end
    apply_drivers();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_acc.size() > 0 || exp_tx.size() > 0 || busy || start_exp) && n < 5000) begin
      cycle();
      n++;
    end
    check(tag, (n < 5000), 1);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
      gap[i] = 0;
    end
    exp_acc.delete();
    exp_tx.delete();
    rr_m = 0;
    start_exp = 1'b0;
    apply_drivers();
    cycle();
    start_exp = 1'b0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    rstn = 1'b1;
  endtask

  initial begin
    int s0, n, to0, g0;
    for (int i = 0; i < NREQ; i++) gap[i] = 0;
    apply_drivers();
    do_reset("rst0");
    cycle();

    // 1: "HI" from requester 0
    s0 = nstart;
    load_byte(0, 8'h48, 1'b0);
    load_byte(0, 8'h49, 1'b1);
    plan();
    apply_drivers();
    wait_drain("t1_drain");
    check("t1_starts", nstart - s0, 2);
    check("t1_busy", busy, 0);

    // 2: requesters 1 and 2, three bytes each; req_ready checked every cycle
    load_msg(1, 3);
    load_msg(2, 3);
    plan();
    apply_drivers();
    wait_drain("t2_drain");

    // 3: 0 and 3 with back-to-back single-byte messages
    grant_log.delete();
    load_msg(0, 1); load_msg(0, 1);
    load_msg(3, 1); load_msg(3, 1);
    plan();
    apply_drivers();
    wait_drain("t3_drain");
    check("t3_n", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("t3_g0", grant_log[0], 3);
      check("t3_g1", grant_log[1], 0);
      check("t3_g2", grant_log[2], 3);
      check("t3_g3", grant_log[3], 0);
    end

    // 4: owner 1 stalls after a non-last byte; requester 2 pending
    to0 = nto;
    drv_q[1].push_back({1'b0, 8'hA5});
    begin
      xfer_t x;
      x.own = 1;
      x.data = 8'hA5;
      exp_acc.push_back(x);
    end
    rr_m = 2;
    load_msg(2, 2);
    plan();
    apply_drivers();
    n = 0;
    while (nto == to0 && n < 200) begin cycle(); n++; end
    check("t4_timeout_seen", nto - to0, 1);
    check("t4_timeout_delay", to_cyc - fire_cyc, 23 + TIMEOUT);
    wait_drain("t4_drain");
    check("t4_single_pulse", nto - to0, 1);

    // 5: reset during WAIT_DONE of a two-byte message
    s0 = nstart;
    load_msg(3, 2);
    plan();
    apply_drivers();
    n = 0;
    while (nstart == s0 && n < 100) begin cycle(); n++; end
    check("t5_first_start", nstart - s0, 1);
    for (int k = 0; k < 8; k++) cycle();
    do_reset("t5_rst");
    s0 = nstart;
    for (int k = 0; k < 10; k++) cycle();
    check("t5_no_start", nstart - s0, 0);
    check("t5_idle_busy", busy, 0);

    // 6: transmitter held not-ready while the owner is valid
    hold_low = 1'b1;
    s0 = nstart;
    g0 = 2;
    load_msg(g0, 1);
    plan();
    apply_drivers();
    for (int k = 0; k < 12; k++) cycle();
    check("t6_busy", busy, 1);
    check("t6_grant", grant, g0);
    check("t6_req_ready", req_ready, 0);
    check("t6_no_start", nstart - s0, 0);
    hold_low = 1'b0;
    wait_drain("t6_drain");
    check("t6_one_start", nstart - s0, 1);

    // randomized traffic with owner gaps shorter than the timeout window
    to0 = nto;
    gmax = 25;
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < NREQ; r++)
        if ($urandom_range(0, 1) == 1)
          for (int m = 0; m < int'($urandom_range(1, 2)); m++)
            load_msg(r, int'($urandom_range(1, 4)));
      plan();
      apply_drivers();
      wait_drain("rnd_drain");
      for (int k = 0; k < 3; k++) cycle();
      check("rnd_idle_busy", busy, 0);
    end
    check("rnd_no_timeout", nto - to0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
